fifo_arbiter: RTL and testbench
===============================

FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  SIZEDATA  32  payload width per requester and on the output.
  NUMREQ    4   number of requesters (2..16).
  MAXBURST  8   maximum beats per grant (1..255).
REQ-002 Ports SHALL be, one per line:
  clk_i    input   1                 single clock, rising edge.
  rstn_i   input   1                 asynchronous active-low reset.
  valid_i  input   NUMREQ            per-requester valid.
  data_i   input   NUMREQ*SIZEDATA   per-requester payload; requester k occupies bits [k*SIZEDATA +: SIZEDATA].
  last_i   input   NUMREQ            per-requester end-of-packet flag, qualified by valid_i[k].
  ready_o  output  NUMREQ            per-requester ready.
  valid_o  output  1                 valid towards the downstream FIFO write port.
  data_o   output  SIZEDATA          payload towards the FIFO.
  last_o   output  1                 end-of-packet towards the FIFO.
  ready_i  input   1                 FIFO write-side ready, i.e. not full.
  grant_o  output  NUMREQ            one-hot registered grant, all-zero when idle.
  busy_o   output  1                 1 while in state BUSY.

Function
REQ-003 The block SHALL share one FIFO write port among NUMREQ requesters using round-robin arbitration with packet lock.
REQ-004 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-005 In IDLE, valid_o, ready_o and grant_o SHALL all be 0.
REQ-006 In IDLE with valid_i nonzero, the winner SHALL be the first index k with valid_i[k]=1, searching upward from rr_ptr and wrapping modulo NUMREQ.
REQ-007 On that cycle's clock edge, grant_o SHALL become one-hot on the winner and the state SHALL become BUSY; the arbitration latency is 1 cycle from valid to grant.
REQ-008 In BUSY with granted index g, the datapath SHALL be combinational:
  valid_o = valid_i[g]; data_o = data_i[g]; last_o = last_i[g]; ready_o[g] = ready_i.
  All other ready_o bits SHALL be 0.
REQ-009 A beat SHALL be a cycle with valid_o && ready_i; beat_cnt SHALL increment by 1 on each beat and return to 0 on release.
REQ-010 Release SHALL occur on a beat where last_i[g]=1 or beat_cnt==MAXBURST-1.
REQ-011 On the release edge, the state SHALL become IDLE, grant_o SHALL become 0, and rr_ptr SHALL become (g+1) mod NUMREQ.
REQ-012 A new grant SHALL NOT be issued in the same cycle as a release; each packet therefore costs at least 1 idle cycle.
REQ-013 In BUSY, if valid_i[g] drops, the grant SHALL be held indefinitely and no beat is counted.
REQ-014 In BUSY, if ready_i=0 (FIFO full), the grant SHALL be held, ready_o SHALL be 0, and no beat is counted.
REQ-015 In BUSY, changes on non-granted valid_i bits SHALL have no effect.
REQ-016 A packet longer than MAXBURST SHALL be split. The remainder SHALL re-arbitrate, and last_o SHALL be forwarded unmodified, so it is 0 on the forced-release beat.
REQ-017 rr_ptr width SHALL be $clog2(NUMREQ); wrap SHALL be explicit for non-power-of-2 NUMREQ.
REQ-018 beat_cnt width SHALL be $clog2(MAXBURST+1).
REQ-019 busy_o SHALL equal (state==BUSY), and grant_o SHALL be nonzero exactly when busy_o=1.

Reset
REQ-020 When rstn_i=0, the block SHALL asynchronously set state=IDLE, grant_o=0, rr_ptr=0 and beat_cnt=0.
REQ-021 During reset and on the first cycle after reset, outputs SHALL be: valid_o=0, ready_o=0, busy_o=0, last_o=0.
REQ-022 data_o SHALL be don't-care while valid_o=0.
REQ-023 Reset asserted mid-packet SHALL drop the grant immediately without completing the beat. After reset release, arbitration SHALL restart from requester 0.

Verification
REQ-024 Single requester: valid_i=0b0100, a 3-beat packet with last on beat 3, ready_i=1 -> grant_o=0b0100 one cycle later, 3 beats on data_o, release, rr_ptr=3.
REQ-025 Fairness: all four valid_i held high, 1-beat packets -> grant order 0,1,2,3,0, with one idle cycle between grants.
REQ-026 Burst limit: MAXBURST=8, requester 1 sends 10 beats with last on beat 10, requester 2 pending -> 8 beats from requester 1 with last_o=0, then requester 2, then the remaining 2 beats from requester 1.
REQ-027 Backpressure: ready_i=0 for 5 cycles mid-packet -> ready_o=0, no beats counted, grant held, and data order preserved.
REQ-028 Reset mid-packet: rstn_i pulsed low during beat 2 of requester 3 -> grant_o=0 immediately; after release, valid_i=0b1001 -> requester 0 granted first.
REQ-029 Granted-requester stall: valid_i[g] low for 4 cycles mid-packet while others request -> grant held, then the packet completes normally.

Source files
------------

// File: rtl/fifo_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_arbiter
// Shares one downstream FIFO write port among NUMREQ requesters. Arbitration is
// round-robin with packet lock. A grant is held until the granted requester
// presents its end-of-packet beat, or until MAXBURST beats have been accepted.
// After every release the block spends at least one cycle in IDLE before it
// issues the next grant.
//
// Ports
//   clk_i    : clock, rising edge
//   rstn_i   : asynchronous active-low reset
//   valid_i  : per-requester valid            [NUMREQ]
//   data_i   : per-requester payload, requester k at [k*SIZEDATA +: SIZEDATA]
//   last_i   : per-requester end-of-packet    [NUMREQ]
//   ready_o  : per-requester ready            [NUMREQ]
//   valid_o  : write valid towards the FIFO
//   data_o   : write payload towards the FIFO
//   last_o   : end-of-packet towards the FIFO
//   ready_i  : FIFO not full
//   grant_o  : registered one-hot grant, zero while idle
//   busy_o   : high while a grant is active
// -----------------------------------------------------------------------------
module fifo_arbiter #(
    parameter int SIZEDATA = 32,
    parameter int NUMREQ   = 4,
    parameter int MAXBURST = 8
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [NUMREQ-1:0]            valid_i,
    input  logic [NUMREQ*SIZEDATA-1:0]   data_i,
    input  logic [NUMREQ-1:0]            last_i,
    output logic [NUMREQ-1:0]            ready_o,
    output logic                         valid_o,
    output logic [SIZEDATA-1:0]          data_o,
    output logic                         last_o,
    input  logic                         ready_i,
    output logic [NUMREQ-1:0]            grant_o,
    output logic                         busy_o
);

    localparam int PTRW = $clog2(NUMREQ);
    localparam int CNTW = $clog2(MAXBURST + 1);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(NUMREQ - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAXBURST - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUMREQ-1:0]   grant_q, grant_d;
    logic [PTRW-1:0]     gidx_q, gidx_d;
    logic [PTRW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]     beat_cnt_q, beat_cnt_d;

    logic [SIZEDATA-1:0] data_arr_s [NUMREQ];
    logic [PTRW-1:0]     win_idx_s;
    logic [PTRW-1:0]     cand_s;
    logic                found_s;
    logic                beat_s;
    logic                release_s;

    // Unpack the flat payload bus so the granted lane can be picked by index.
    for (genvar k = 0; k < NUMREQ; k++) begin : g_unpack
        assign data_arr_s[k] = data_i[k*SIZEDATA +: SIZEDATA];
    end

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    // The wrap is a compare against NUMREQ-1 so non-power-of-2 counts work.
    always_comb begin
        found_s   = 1'b0;
        win_idx_s = '0;
        cand_s    = rr_ptr_q;
        for (int i = 0; i < NUMREQ; i++) begin
            if (!found_s && valid_i[cand_s]) begin
                found_s   = 1'b1;
                win_idx_s = cand_s;
            end else begin
                found_s   = found_s;
            end
            if (cand_s == PTR_LAST) begin
                cand_s = '0;
            end else begin
                cand_s = cand_s + PTRW'(1);
            end
        end
    end

    // Combinational datapath from the granted requester to the FIFO port.
    always_comb begin
        valid_o = 1'b0;
        data_o  = '0;
        last_o  = 1'b0;
        ready_o = '0;
        if (state_q == BUSY) begin
            valid_o         = valid_i[gidx_q];
            data_o          = data_arr_s[gidx_q];
            last_o          = last_i[gidx_q];
            ready_o[gidx_q] = ready_i;
        end else begin
            valid_o = 1'b0;
        end
    end

    // A stalled requester or a full FIFO produces no beat. Release on the
    // end-of-packet beat or on the beat that fills the burst budget.
    assign beat_s    = (state_q == BUSY) && valid_o && ready_i;
    assign release_s = beat_s && (last_o || (beat_cnt_q == CNT_LAST));

    // Next-state logic for the arbitration FSM and its bookkeeping.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d    = BUSY;
                    gidx_d     = win_idx_s;
                    grant_d    = {{(NUMREQ-1){1'b0}}, 1'b1} << win_idx_s;
                    beat_cnt_d = '0;
                end else begin
                    grant_d    = '0;
                end
            end
            BUSY: begin
                if (release_s) begin
                    // Going through IDLE guarantees one idle cycle per packet.
                    state_d    = IDLE;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                    if (gidx_q == PTR_LAST) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gidx_q + PTRW'(1);
                    end
                end else if (beat_s) begin
                    beat_cnt_d = beat_cnt_q + CNTW'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                beat_cnt_d = '0;
            end
        endcase
    end

    // FSM state and registered grant; reset drops any grant immediately.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == BUSY);

endmodule

// File: tb/tb_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_arbiter
// Directed bench for fifo_arbiter (SIZEDATA=32, NUMREQ=4, MAXBURST=8).
// Per-requester packet queues feed the DUT. Each test pushes the hand-ordered
// output beats it expects into a scoreboard queue, and a separate monitor
// compares every accepted FIFO beat against that queue. Cycle-level checks of
// grant, busy and ready are made directly in the sequencer.
// -----------------------------------------------------------------------------
module tb_fifo_arbiter;

    logic         clk;
    logic         rstn_i;
    logic [3:0]   valid_i;
    logic [127:0] data_i;
    logic [3:0]   last_i;
    logic [3:0]   ready_o;
    logic         valid_o;
    logic [31:0]  data_o;
    logic         last_o;
    logic         ready_i;
    logic [3:0]   grant_o;
    logic         busy_o;

    fifo_arbiter #(.SIZEDATA(32), .NUMREQ(4), .MAXBURST(8)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .last_o  (last_o),
        .ready_i (ready_i),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [32:0]  rq [4][$];     // per-requester beats: {last, data}
    logic [36:0]  exp_q [$];     // expected FIFO beats: {grant, last, data}
    logic [3:0]   stall = 4'b0000;
    logic [3:0]   hs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] bd(input logic [7:0] tag, input int b);
        return {tag, 16'h0000, 8'(b)};
    endfunction

    // Queue an n-beat packet on requester k, last flag on beat n.
    task automatic pkt(input int k, input logic [7:0] tag, input int n);
        for (int b = 1; b <= n; b++) rq[k].push_back({(b == n), bd(tag, b)});
    endtask

    task automatic push_exp(input int k, input logic [31:0] d, input logic l);
        logic [3:0] g;
        g = 4'b0001 << k;
        exp_q.push_back({g, l, d});
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        step();
    endtask

    // Requester models: present the head beat unless stalled, pop on handshake.
    initial begin : driver
        logic [3:0]  vtmp;
        logic [3:0]  ltmp;
        logic [31:0] rd [4];
        hs      = 4'b0000;
        valid_i = 4'b0000;
        last_i  = 4'b0000;
        data_i  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (hs[2'(k)] && rq[k].size() > 0) void'(rq[k].pop_front());
            end
            vtmp = 4'b0000;
            ltmp = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                rd[k] = 32'h0;
                if (rq[k].size() > 0 && !stall[2'(k)]) begin
                    vtmp[2'(k)] = 1'b1;
                    rd[k]       = rq[k][0][31:0];
                    ltmp[2'(k)] = rq[k][0][32];
                end
            end
            valid_i = vtmp;
            last_i  = ltmp;
            data_i  = {rd[3], rd[2], rd[1], rd[0]};
            #3;
            hs = valid_i & ready_o;
        end
    end

    // Scoreboard monitor: every accepted FIFO beat must match the queue head.
    initial begin : monitor
        logic [36:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (rstn_i && valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat actual=%0h required=none", {grant_o, last_o, data_o});
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'({grant_o, last_o, data_o}), 64'(e));
                end
            end
        end
    end

    initial begin : sequencer
        rstn_i  = 1'b0;
        ready_i = 1'b1;
        step();
        step();
        // Outputs during reset
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_ready_o", 64'(ready_o), 64'd0);
        chk("rst_busy_o",  64'(busy_o),  64'd0);
        chk("rst_grant_o", 64'(grant_o), 64'd0);
        chk("rst_last_o",  64'(last_o),  64'd0);
        rstn_i = 1'b1;
        step();
        chk("post_rst_busy", 64'(busy_o), 64'd0);

        // Single requester 2, 3-beat packet, one cycle arbitration latency
        for (int b = 1; b <= 3; b++) push_exp(2, bd(8'h11, b), (b == 3));
        pkt(2, 8'h11, 3);
        step();
        chk("single_valid_seen", 64'(valid_i), 64'h4);
        chk("single_no_grant_yet", 64'(grant_o), 64'h0);
        step();
        chk("single_grant", 64'(grant_o), 64'h4);
        chk("single_busy", 64'(busy_o), 64'd1);
        chk("single_ready", 64'(ready_o), 64'h4);
        step(); step(); step();
        chk("single_release_grant", 64'(grant_o), 64'h0);
        chk("single_release_busy", 64'(busy_o), 64'd0);
        drain("single_drain", 20);

        // rr_ptr is now 3: requester 3 beats requester 0
        push_exp(3, bd(8'h21, 1), 1'b1);
        push_exp(0, bd(8'h20, 1), 1'b1);
        pkt(0, 8'h20, 1);
        pkt(3, 8'h21, 1);
        drain("rrptr_drain", 20);

        // Reset while idle restarts the pointer at 0; fairness with 1-beat packets
        rstn_i = 1'b0;
        step();
        rstn_i = 1'b1;
        step();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                pkt(k, 8'(8'h30 + 8'(k)), 1);
                push_exp(k, bd(8'(8'h30 + 8'(k)), 1), 1'b1);
            end
        end
        step();
        step();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] g;
            g = ((i % 2) == 0) ? (4'b0001 << ((i / 2) % 4)) : 4'b0000;
            chk("fair_grant", 64'(grant_o), 64'(g));
            step();
        end
        drain("fair_drain", 20);

        // Burst limit: 10-beat packet split 8 + 2 around requester 2
        for (int b = 1; b <= 8; b++) push_exp(1, bd(8'h41, b), 1'b0);
        push_exp(2, bd(8'h42, 1), 1'b0);
        push_exp(2, bd(8'h42, 2), 1'b1);
        push_exp(1, bd(8'h41, 9), 1'b0);
        push_exp(1, bd(8'h41, 10), 1'b1);
        pkt(1, 8'h41, 10);
        pkt(2, 8'h42, 2);
        drain("burst_drain", 60);

        // Backpressure: 5 cycles of FIFO full after beat 2 of a 6-beat packet
        for (int b = 1; b <= 6; b++) push_exp(0, bd(8'h50, b), (b == 6));
        pkt(0, 8'h50, 6);
        step();
        step();
        chk("bp_grant", 64'(grant_o), 64'h1);
        step();
        step();
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready_o", 64'(ready_o), 64'h0);
            chk("bp_grant_held", 64'(grant_o), 64'h1);
            step();
        end
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_still_busy", 64'({busy_o, grant_o}), 64'h11);
            step();
        end
        #1;
        chk("bp_released", 64'(busy_o), 64'd0);
        drain("bp_drain", 20);

        // Reset during beat 2 of requester 3
        push_exp(3, bd(8'h63, 1), 1'b0);
        pkt(3, 8'h63, 4);
        step();
        step();
        chk("rstmid_grant", 64'(grant_o), 64'h8);
        step();
        #1;
        rstn_i = 1'b0;
        #1;
        chk("rstmid_grant_drop", 64'(grant_o), 64'h0);
        chk("rstmid_outputs", 64'({busy_o, valid_o, ready_o, last_o}), 64'h0);
        rq[3].delete();
        step();
        step();
        rstn_i = 1'b1;
        step();
        chk("rstmid_after_outputs", 64'({busy_o, valid_o, ready_o, last_o}), 64'h0);
        push_exp(0, bd(8'h70, 1), 1'b1);
        push_exp(3, bd(8'h73, 1), 1'b1);
        pkt(0, 8'h70, 1);
        pkt(3, 8'h73, 1);
        step();
        step();
        chk("rstmid_first_grant", 64'(grant_o), 64'h1);
        drain("rstmid_drain", 20);

        // Granted requester 2 stalls 4 cycles while 0 and 1 request
        for (int b = 1; b <= 4; b++) push_exp(2, bd(8'h82, b), (b == 4));
        push_exp(0, bd(8'h80, 1), 1'b1);
        push_exp(1, bd(8'h81, 1), 1'b1);
        pkt(2, 8'h82, 4);
        step();
        step();
        chk("stall_grant", 64'(grant_o), 64'h4);
        step();
        stall = 4'b0100;
        pkt(0, 8'h80, 1);
        pkt(1, 8'h81, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stall_held", 64'({grant_o, valid_o}), 64'h8);
            step();
        end
        stall = 4'b0000;
        drain("stall_drain", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
